fsm_timer_resp: RTL and testbench

- Timer responder on the far end of the FSM_COM timing interface.
- The controller requests a timed interval by driving its 2-bit Gen command.
- This block counts the interval and returns the 2-bit T expiry flags that the controller samples as an input.
- It sits beside the controller and shares its clock and reset. It supports short and long intervals, pause and abort.

---
 rtl/fsm_timer_resp.sv | 162 ++++++++++++++++
 tb/tb_fsm_timer_resp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_timer_resp.sv
// Purpose: timer responder; counts short/long intervals on request from the FSM_COM controller and pulses T on expiry.
// Latency: T pulse registered TICKS*PRESCALE clk edges after the edge that samples the start command.
// Backpressure: none; commands act only on Gen edges, and the T pulse is one cycle wide and not held.
module fsm_timer_resp #(
   parameter int PRESCALE    = 4,
   parameter int SHORT_TICKS = 5,
   parameter int LONG_TICKS  = 10,
   parameter int CW          = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    Gen,
   output logic [1:0]    T,
   output logic          busy,
   output logic [CW-1:0] remaining
);

   // Prescaler needs at least one bit even when PRESCALE==1 (tick every cycle).
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] SHORT_LEN = CW'(SHORT_TICKS);
   localparam logic [CW-1:0] LONG_LEN  = CW'(LONG_TICKS);

   localparam logic [1:0] GEN_IDLE  = 2'b00;
   localparam logic [1:0] GEN_SHORT = 2'b01;
   localparam logic [1:0] GEN_LONG  = 2'b10;
   localparam logic [1:0] GEN_PAUSE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN_S,
      ST_RUN_L,
      ST_PAUSE,
      ST_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    gen_q;
   logic [PW-1:0] prescaler;
   logic [PW-1:0] prescaler_nxt;
   logic [CW-1:0] remaining_nxt;
   logic [1:0]    t_nxt;
   logic          busy_nxt;
   logic          paused_long;
   logic          paused_long_nxt;
   logic          load;
   logic          load_long;
   logic          cmd_edge;
   logic          tick;

   // A command is only a change of Gen; a held level never re-executes.
   assign cmd_edge = (Gen != gen_q);
   assign tick     = (prescaler == PS_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath decode; a command edge always wins over a tick in the same cycle.
   always_comb begin
      state_nxt       = state;
      prescaler_nxt   = prescaler;
      remaining_nxt   = remaining;
      t_nxt           = 2'b00;
      busy_nxt        = busy;
      paused_long_nxt = paused_long;
      load            = 1'b0;
      load_long       = 1'b0;

      if (cmd_edge) begin
         unique case (Gen)
            GEN_IDLE: begin
               // Abort (or leave DONE): drop any pending expiry.
               state_nxt     = ST_IDLE;
               prescaler_nxt = '0;
               remaining_nxt = '0;
               busy_nxt      = 1'b0;
            end
            GEN_SHORT: begin
               if (state == ST_PAUSE && !paused_long) begin
                  state_nxt = ST_RUN_S;
               end else begin
                  load      = 1'b1;
                  load_long = 1'b0;
               end
            end
            GEN_LONG: begin
               if (state == ST_PAUSE && paused_long) begin
                  state_nxt = ST_RUN_L;
               end else begin
                  load      = 1'b1;
                  load_long = 1'b1;
               end
            end
            GEN_PAUSE: begin
               // Pause only means something while counting; elsewhere it is ignored.
               if (state == ST_RUN_S || state == ST_RUN_L) begin
                  state_nxt       = ST_PAUSE;
                  paused_long_nxt = (state == ST_RUN_L);
               end
            end
         endcase
      end else begin
         unique case (state)
            ST_RUN_S, ST_RUN_L: begin
               if (tick) begin
                  prescaler_nxt = '0;
                  if (remaining > CW'(1)) begin
                     remaining_nxt = remaining - 1'b1;
                  end else begin
                     remaining_nxt = '0;
                     t_nxt         = (state == ST_RUN_L) ? 2'b10 : 2'b01;
                     busy_nxt      = 1'b0;
                     state_nxt     = ST_DONE;
                  end
               end else begin
                  prescaler_nxt = prescaler + 1'b1;
               end
            end
            default: begin
               // IDLE, PAUSE and DONE hold their counters; T falls back to 00.
            end
         endcase
      end

      // Fresh start of either length, from any state.
      if (load) begin
         state_nxt       = load_long ? ST_RUN_L : ST_RUN_S;
         prescaler_nxt   = '0;
         remaining_nxt   = load_long ? LONG_LEN : SHORT_LEN;
         busy_nxt        = 1'b1;
         paused_long_nxt = load_long;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gen_q       <= GEN_IDLE;
         prescaler   <= '0;
         remaining   <= '0;
         T           <= 2'b00;
         busy        <= 1'b0;
         paused_long <= 1'b0;
      end else begin
         gen_q       <= Gen;
         prescaler   <= prescaler_nxt;
         remaining   <= remaining_nxt;
         T           <= t_nxt;
         busy        <= busy_nxt;
         paused_long <= paused_long_nxt;
      end
   end

endmodule

// File: tb/tb_fsm_timer_resp.sv
// Purpose: self-checking bench for fsm_timer_resp; expected T pulses are queued at stimulus time.
// Latency: pulses are matched against the exact clk edge at which they must be registered.
// Backpressure: none; the monitor consumes every nonzero T as it appears.
module tb_fsm_timer_resp;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Gen;
   logic [1:0] T;
   logic       busy;
   logic [7:0] remaining;

   typedef struct {
      int         cyc;
      logic [1:0] t;
   } pulse_t;

   pulse_t exp_q[$];
   pulse_t got;
   int     cyc    = 0;
   int     checks = 0;
   int     errors = 0;
   bit     mon_en = 1'b0;

   fsm_timer_resp #(
      .PRESCALE   (4),
      .SHORT_TICKS(5),
      .LONG_TICKS (10),
      .CW         (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .Gen      (Gen),
      .T        (T),
      .busy     (busy),
      .remaining(remaining)
   );

   always #5 clk = ~clk;

   // cyc equals the number of rising edges seen; read at falling edges.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic expect_pulse(input int c, input logic [1:0] t);
      pulse_t p;
      p.cyc = c;
      p.t   = t;
      exp_q.push_back(p);
   endtask

   // Monitor: every nonzero T must match the oldest queued pulse in value and edge number.
   always @(negedge clk) begin
      if (mon_en && T != 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_t", int'(T), 0);
         end else begin
            got = exp_q.pop_front();
            chk("t_cycle", cyc, got.cyc);
            chk("t_value", int'(T), int'(got.t));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      Gen   = 2'b00;

      // Reset state.
      wait_to(3);
      chk("rst_t", int'(T), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_remaining", int'(remaining), 0);
      reset  = 1'b1;
      mon_en = 1'b1;

      // Short interval: start sampled at edge 6, pulse at 26; holding 01 gives nothing more.
      wait_to(5);
      Gen = 2'b01;
      expect_pulse(26, 2'b01);
      wait_to(7);
      chk("short_remaining_start", int'(remaining), 5);
      chk("short_busy_start", int'(busy), 1);
      wait_to(26);
      chk("short_busy_end", int'(busy), 0);
      chk("short_remaining_end", int'(remaining), 0);

      // Long interval from DONE: start at 61, remaining steps down every 4 edges, pulse at 101.
      wait_to(60);
      Gen = 2'b10;
      expect_pulse(101, 2'b10);
      for (int k = 0; k < 10; k++) begin
         wait_to(61 + 4 * k + 2);
         chk("long_remaining_step", int'(remaining), 10 - k);
      end
      wait_to(105);
      Gen = 2'b00;
      wait_to(108);
      Gen = 2'b01;
      expect_pulse(129, 2'b01);
      wait_to(111);
      chk("restart_short_remaining", int'(remaining), 5);
      chk("restart_short_busy", int'(busy), 1);

      // Pause/resume: start at 139, pause edge 149 (remaining 3), resume edge 165, pulse 11 later.
      wait_to(135);
      Gen = 2'b00;
      wait_to(138);
      Gen = 2'b01;
      wait_to(148);
      chk("pause_remaining_before", int'(remaining), 3);
      Gen = 2'b11;
      wait_to(150);
      chk("pause_remaining_early", int'(remaining), 3);
      chk("pause_busy", int'(busy), 1);
      wait_to(164);
      chk("pause_remaining_late", int'(remaining), 3);
      Gen = 2'b01;
      expect_pulse(176, 2'b01);

      // Abort: long start at 181, abort edge 193; no pulse ever.
      wait_to(180);
      Gen = 2'b10;
      wait_to(192);
      Gen = 2'b00;
      wait_to(194);
      chk("abort_busy", int'(busy), 0);
      chk("abort_remaining", int'(remaining), 0);

      // Switch long to short: long at 241, short edge 253, pulse 20 later.
      wait_to(240);
      Gen = 2'b10;
      wait_to(252);
      Gen = 2'b01;
      expect_pulse(273, 2'b01);
      wait_to(254);
      chk("switch_remaining", int'(remaining), 5);
      chk("switch_busy", int'(busy), 1);

      // Priority: long at 281 would expire at 321; abort sampled at 321 wins.
      wait_to(280);
      Gen = 2'b10;
      wait_to(320);
      chk("prio_remaining_last", int'(remaining), 1);
      Gen = 2'b00;
      wait_to(322);
      chk("prio_busy", int'(busy), 0);
      chk("prio_remaining", int'(remaining), 0);

      // Reset mid-run: long at 331, reset edge 356, fresh long at 361 pulses at 401.
      wait_to(330);
      Gen = 2'b10;
      wait_to(355);
      reset = 1'b0;
      Gen   = 2'b00;
      wait_to(356);
      chk("midrst_t", int'(T), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_remaining", int'(remaining), 0);
      reset = 1'b1;
      wait_to(360);
      Gen = 2'b10;
      expect_pulse(401, 2'b10);
      wait_to(400);
      chk("fresh_remaining_last", int'(remaining), 1);
      chk("fresh_busy_last", int'(busy), 1);
      wait_to(401);
      chk("fresh_busy_end", int'(busy), 0);

      wait_to(410);
      chk("pending_pulses", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
